// File: rtl/baud_gen.sv
// Programmable divider producing the single-cycle UART oversampling tick.
// Emits one registered pulse every div_i clocks while enabled. div_i == 0 never ticks.
module baud_gen #(
  parameter int unsigned OSR   = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             osr_tick_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  // Elaboration-time parameter range checks
  if (OSR < 1) begin : g_bad_osr
    $error("baud_gen: OSR must be >= 1");
  end
  if (DIV_W < 1) begin : g_bad_div_w
    $error("baud_gen: DIV_W must be >= 1");
  end

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic             tick_nxt_s;

  // Next counter and tick: a divisor change, disable or zero divisor restarts the period
  always_comb begin
    cnt_nxt_s  = '0;
    tick_nxt_s = 1'b0;
    if (div_i != div_r) begin
      cnt_nxt_s  = '0;
      tick_nxt_s = 1'b0;
    end else if (!en_i || (div_i == '0)) begin
      cnt_nxt_s  = '0;
      tick_nxt_s = 1'b0;
    end else if (cnt_r == (div_i - ONE)) begin
      cnt_nxt_s  = '0;
      tick_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s  = cnt_r + ONE;
      tick_nxt_s = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r      <= '0;
      div_r      <= '0;
      osr_tick_o <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      div_r      <= div_i;
      osr_tick_o <= tick_nxt_s;
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: directed test-plan steps followed by random
// stimulus, all checked against a run-length reference model.
module tb_baud_gen;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset_i = 1'b0;
  logic             en_i = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic             osr_tick_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: divisor seen last edge, enabled edges since the period began
  int m_prev_div = 0;
  int m_run      = 0;
  bit m_exp      = 1'b0;

  baud_gen #(.OSR(16), .DIV_W(DIV_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .div_i      (div_i),
    .osr_tick_o (osr_tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    n_checks++;
    assert (osr_tick_o === m_exp) else begin
      n_fails++;
      $error("FAIL %s: observed osr_tick_o=%b expected %b", tag, osr_tick_o, m_exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by one edge, check 1 time unit later
  task automatic step(input bit rst, input bit en, input int div, input string tag);
    @(negedge clk);
    reset_i = rst;
    en_i    = en;
    div_i   = DIV_W'(div);
    @(posedge clk);
    if (rst) begin
      m_prev_div = 0;
      m_run      = 0;
      m_exp      = 1'b0;
    end else if (div != m_prev_div || !en || div == 0) begin
      m_prev_div = div;
      m_run      = 0;
      m_exp      = 1'b0;
    end else begin
      m_run++;
      m_exp = ((m_run % div) == 0);
    end
    #1;
    check(tag);
  endtask

  initial begin
    int div_cur;
    int ticks;

    // Reset and disabled
    step(1'b1, 1'b0, 0, "reset0");
    step(1'b1, 1'b0, 0, "reset1");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4, "disabled");

    // Periodic ticks at div 4: high after edges 4 and 8 only
    ticks = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, 4, "periodic4");
      if (osr_tick_o === 1'b1) ticks++;
    end
    n_checks++;
    assert (ticks === 2) else begin
      n_fails++;
      $error("FAIL tick_count4: observed %0d expected %0d", ticks, 2);
    end

    // Bring the counter to a fresh period, run 3 edges, then disable before terminal count
    step(1'b0, 1'b0, 4, "realign");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4, "pre_disable");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4, "disable_before_tc");

    // Divisor change before terminal count
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4, "pre_change");
    step(1'b0, 1'b1, 5, "change_edge");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 5, "period5");

    // Edge divisors
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, "div1");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0, "div0");

    // Reset mid-operation at count 2
    step(1'b0, 1'b0, 4, "pre_reset_align");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4, "pre_reset");
    step(1'b1, 1'b1, 4, "mid_reset");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4, "post_reset");

    // Random stimulus: mostly enabled, occasional divisor changes, rare resets
    div_cur = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) div_cur = int'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) div_cur = 255;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), div_cur, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
